// File: rtl/mem256x16_pkg.sv
// Shared constants and the address-packing helper for the 256x16 banked RAM.
package mem256x16_pkg;

  localparam int DATA_W      = 16;
  localparam int ADDR_W      = 8;
  localparam int BANK_ADDR_W = 5;
  localparam int NUM_BANKS   = 8;
  localparam int BANK_DEPTH  = 32;
  localparam int DEPTH       = NUM_BANKS * BANK_DEPTH;
  localparam int BANK_SEL_W  = ADDR_W - BANK_ADDR_W;

  // Reassembles the board-level discrete address bits, b7 being the MSB.
  function automatic logic [ADDR_W-1:0] addr_pack(
    input logic b7, input logic b6, input logic b5, input logic b4,
    input logic b3, input logic b2, input logic b1, input logic b0
  );
    return {b7, b6, b5, b4, b3, b2, b1, b0};
  endfunction

endpackage

// File: rtl/ram32x16_bank.sv
// One 32x16 storage bank: synchronous write on its own enable, combinational
// read, asynchronous clear of every word.
module ram32x16_bank
  import mem256x16_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [BANK_ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata
);

  logic [DATA_W-1:0] mem_q [BANK_DEPTH];
  logic [DATA_W-1:0] mem_d [BANK_DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[addr] = wdata;
    end else begin
      mem_d[addr] = mem_q[addr];
    end
  end

  // Reset has priority over the clock, so a write pending at assertion is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BANK_DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem256x16_ram.sv
// 256x16 single-port RAM: eight 32-word banks behind a 3-to-8 write decoder
// and an 8:1 combinational read mux.
module mem256x16_ram
  import mem256x16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              addr0,
  input  logic              addr1,
  input  logic              addr2,
  input  logic              addr3,
  input  logic              addr4,
  input  logic              addr5,
  input  logic              addr6,
  input  logic              addr7,
  input  logic              WEn,
  output logic [DATA_W-1:0] qout
);

  logic [ADDR_W-1:0]      addr_s;
  logic [BANK_SEL_W-1:0]  bank_sel_s;
  logic [BANK_ADDR_W-1:0] word_s;
  logic [NUM_BANKS-1:0]   bank_we_s;
  logic [DATA_W-1:0]      bank_rd_s [NUM_BANKS];
  logic [DATA_W-1:0]      rd_mux_s;

  assign addr_s     = addr_pack(addr7, addr6, addr5, addr4,
                                addr3, addr2, addr1, addr0);
  assign bank_sel_s = addr_s[ADDR_W-1:BANK_ADDR_W];
  assign word_s     = addr_s[BANK_ADDR_W-1:0];

  always_comb begin
    bank_we_s = {NUM_BANKS{1'b0}};
    if (WEn) begin
      bank_we_s[bank_sel_s] = 1'b1;
    end else begin
      bank_we_s = {NUM_BANKS{1'b0}};
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    ram32x16_bank u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (bank_we_s[b]),
      .addr  (word_s),
      .wdata (data),
      .rdata (bank_rd_s[b])
    );
  end

  // Read path stays combinational so qout follows the address with no latency.
  always_comb begin
    rd_mux_s = {DATA_W{1'b0}};
    case (bank_sel_s)
      3'd0:    rd_mux_s = bank_rd_s[0];
      3'd1:    rd_mux_s = bank_rd_s[1];
      3'd2:    rd_mux_s = bank_rd_s[2];
      3'd3:    rd_mux_s = bank_rd_s[3];
      3'd4:    rd_mux_s = bank_rd_s[4];
      3'd5:    rd_mux_s = bank_rd_s[5];
      3'd6:    rd_mux_s = bank_rd_s[6];
      3'd7:    rd_mux_s = bank_rd_s[7];
      default: rd_mux_s = {DATA_W{1'bx}};
    endcase
  end

  assign qout = rd_mux_s;

endmodule

// File: tb/tb_mem256x16_ram.sv
// Directed self-checking bench for mem256x16_ram; expected values hand-computed.
module tb_mem256x16_ram;

  logic        clk;
  logic        rst;
  logic [15:0] data;
  logic        addr0, addr1, addr2, addr3, addr4, addr5, addr6, addr7;
  logic        WEn;
  logic [15:0] qout;

  int n_cmp;
  int n_mis;

  mem256x16_ram dut (
    .clk   (clk),
    .rst   (rst),
    .data  (data),
    .addr0 (addr0),
    .addr1 (addr1),
    .addr2 (addr2),
    .addr3 (addr3),
    .addr4 (addr4),
    .addr5 (addr5),
    .addr6 (addr6),
    .addr7 (addr7),
    .WEn   (WEn),
    .qout  (qout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_addr(input logic [7:0] a);
    {addr7, addr6, addr5, addr4, addr3, addr2, addr1, addr0} = a;
  endtask

  task automatic check(input string tag, input logic [15:0] exp);
    n_cmp++;
    assert (qout === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, qout, exp);
    end
  endtask

  // Drive an address mid low-phase, let it settle, then compare.
  task automatic rd(input string tag, input logic [7:0] a, input logic [15:0] exp);
    @(negedge clk);
    set_addr(a);
    #1;
    check(tag, exp);
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    set_addr(a);
    data = d;
    WEn  = 1'b1;
    @(posedge clk);
    #1;
    WEn  = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst   = 1'b1;
    WEn   = 1'b0;
    data  = 16'h0000;
    set_addr(8'h00);

    // Reset then read
    #12;
    check("rst_hold_a00", 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    rd("rst_a10", 8'h10, 16'h0000);
    rd("rst_a20", 8'h20, 16'h0000);
    rd("rst_a40", 8'h40, 16'h0000);
    rd("rst_a82", 8'h82, 16'h0000);
    rd("rst_a04", 8'h04, 16'h0000);

    // Basic writes, with old-then-new visibility around the edge for 0x01
    wr(8'h00, 16'h0000);
    @(negedge clk);
    set_addr(8'h01);
    data = 16'h0001;
    WEn  = 1'b1;
    #1;
    check("wr01_before_edge", 16'h0000);
    @(posedge clk);
    #1;
    check("wr01_after_edge", 16'h0001);
    WEn = 1'b0;
    wr(8'h02, 16'h0010);
    wr(8'h84, 16'h0006);
    @(negedge clk);
    set_addr(8'h48);
    data = 16'h0012;
    WEn  = 1'b1;
    @(posedge clk);
    #1;
    check("wr48_edge1", 16'h0012);
    @(posedge clk);
    #1;
    check("wr48_edge2", 16'h0012);
    WEn = 1'b0;

    // Address moves while WEn=1: only the address present at the edge is written
    @(negedge clk);
    set_addr(8'h30);
    data = 16'h7777;
    WEn  = 1'b1;
    #2;
    set_addr(8'h31);
    @(posedge clk);
    #1;
    WEn = 1'b0;
    rd("addr_move_a31", 8'h31, 16'h7777);
    rd("addr_move_a30", 8'h30, 16'h0000);

    rd("rb_a00", 8'h00, 16'h0000);
    rd("rb_a01", 8'h01, 16'h0001);
    rd("rb_a02", 8'h02, 16'h0010);
    rd("rb_a84", 8'h84, 16'h0006);
    rd("rb_a48", 8'h48, 16'h0012);
    rd("unw_a10", 8'h10, 16'h0000);
    rd("unw_a20", 8'h20, 16'h0000);
    rd("unw_a40", 8'h40, 16'h0000);
    rd("unw_a82", 8'h82, 16'h0000);
    rd("unw_a04", 8'h04, 16'h0000);

    // Bank boundary isolation
    wr(8'h1F, 16'hAAAA);
    wr(8'h20, 16'h5555);
    rd("iso_a1f", 8'h1F, 16'hAAAA);
    rd("iso_a20", 8'h20, 16'h5555);
    rd("iso_a3f", 8'h3F, 16'h0000);
    rd("iso_a00", 8'h00, 16'h0000);
    rd("iso_a7f", 8'h7F, 16'h0000);
    rd("iso_a80", 8'h80, 16'h0000);

    // Write gating: WEn low across several edges
    @(negedge clk);
    set_addr(8'h84);
    data = 16'hFFFF;
    WEn  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("gate_a84", 16'h0006);

    // Extremes and combinational read tracking within one low phase
    wr(8'h00, 16'h1357);
    wr(8'hFF, 16'hBEEF);
    @(negedge clk);
    set_addr(8'h00);
    #1;
    check("tog_a00_1", 16'h1357);
    set_addr(8'hFF);
    #1;
    check("tog_aff_1", 16'hBEEF);
    set_addr(8'h00);
    #1;
    check("tog_a00_2", 16'h1357);
    set_addr(8'hFF);
    #1;
    check("tog_aff_2", 16'hBEEF);

    // Reset asserted off-edge during a pending write
    @(negedge clk);
    set_addr(8'h01);
    data = 16'h1234;
    WEn  = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_immediate", 16'h0000);
    @(posedge clk);
    #1;
    check("rst_mid_edge_blocked", 16'h0000);
    @(negedge clk);
    WEn = 1'b0;
    #2;
    rst = 1'b0;
    rd("post_rst_a01", 8'h01, 16'h0000);
    rd("post_rst_a84", 8'h84, 16'h0000);
    rd("post_rst_aff", 8'hFF, 16'h0000);
    rd("post_rst_a1f", 8'h1F, 16'h0000);
    rd("post_rst_a20", 8'h20, 16'h0000);
    rd("post_rst_a48", 8'h48, 16'h0000);
    rd("post_rst_a31", 8'h31, 16'h0000);
    wr(8'h01, 16'h1234);
    rd("post_rst_wr_a01", 8'h01, 16'h1234);
    rd("post_rst_wr_a00", 8'h00, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
